// File: rtl/axil_i2s_ctrl_regs.sv
// AXI4-Lite control/status register block for the I2S transmitter path.
//
// Register map (word index):
//   0          VER         read-only, returns VERSION
//   1          CTRL        read/write, drives ctrl_out
//   2          INT_EN      read/write, bits [INT_W-1:0] implemented
//   3          INT_STATUS  write-one-to-clear, set by int_src
//   4..N-1     CFG         read/write, drives cfg_out (register 4 in the LSBs)
// Out-of-range indices answer SLVERR and have no side effects.
//
// Ports:
//   s_axi_ctrl_aclk / s_axi_ctrl_arst  clock, asynchronous active-high reset
//   s_axi_ctrl_aw* / w* / b*           AXI4-Lite write channels (AW and W in any order)
//   s_axi_ctrl_ar* / r*                AXI4-Lite read channels
//   int_src                            per-source interrupt set pulses
//   ctrl_out, cfg_out                  register contents towards the audio datapath
//   irq                                registered |(INT_STATUS & INT_EN)
module axil_i2s_ctrl_regs #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INT_W    = 8,
  parameter logic [31:0] VERSION  = 32'h0002_0000
) (
  input  logic                       s_axi_ctrl_aclk,
  input  logic                       s_axi_ctrl_arst,
  input  logic                       s_axi_ctrl_awvalid,
  output logic                       s_axi_ctrl_awready,
  input  logic [ADDR_W-1:0]          s_axi_ctrl_awaddr,
  input  logic                       s_axi_ctrl_wvalid,
  output logic                       s_axi_ctrl_wready,
  input  logic [31:0]                s_axi_ctrl_wdata,
  input  logic [3:0]                 s_axi_ctrl_wstrb,
  output logic                       s_axi_ctrl_bvalid,
  input  logic                       s_axi_ctrl_bready,
  output logic [1:0]                 s_axi_ctrl_bresp,
  input  logic                       s_axi_ctrl_arvalid,
  output logic                       s_axi_ctrl_arready,
  input  logic [ADDR_W-1:0]          s_axi_ctrl_araddr,
  output logic                       s_axi_ctrl_rvalid,
  input  logic                       s_axi_ctrl_rready,
  output logic [31:0]                s_axi_ctrl_rdata,
  output logic [1:0]                 s_axi_ctrl_rresp,
  input  logic [INT_W-1:0]           int_src,
  output logic [31:0]                ctrl_out,
  output logic [(NUM_REGS-4)*32-1:0] cfg_out,
  output logic                       irq
);

  localparam int unsigned IdxW   = ADDR_W - 2;
  localparam int unsigned NumCfg = NUM_REGS - 4;

  typedef enum logic [2:0] {WIdle, WHaveAw, WHaveW, WCommit, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  // Write channel state
  w_state_e         w_state_q;
  logic             awready_q, wready_q, bvalid_q;
  logic [1:0]       bresp_q;
  logic [IdxW-1:0]  wr_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  // Read channel state
  r_state_e         r_state_q;
  logic             arready_q, rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  // Register file
  logic [31:0]                ctrl_q;
  logic [INT_W-1:0]           int_en_q;
  logic [INT_W-1:0]           int_status_q;
  logic [NumCfg-1:0][31:0]    cfg_q;
  logic                       irq_q;

  logic [31:0]      wr_idx32, rd_idx32;
  logic             wr_commit, wr_oor;
  logic [31:0]      wmask;
  logic [INT_W-1:0] status_clr;
  logic [31:0]      rd_data;
  logic [1:0]       rd_resp;

  // Word-select bits only; the byte offset within a word has no meaning here.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign wr_idx32  = 32'(wr_idx_q);
  assign rd_idx32  = 32'(s_axi_ctrl_araddr[ADDR_W-1:2]);
  assign wr_commit = (w_state_q == WCommit);
  assign wr_oor    = (wr_idx32 >= NUM_REGS);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
    status_clr = '0;
    if (wr_commit && wr_idx32 == 32'd3) begin
      status_clr = wdata_q[INT_W-1:0] & wmask[INT_W-1:0];
    end
  end

  // Write FSM: captures AW and W independently, commits once both are held.
  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_arst) begin
    if (s_axi_ctrl_arst) begin
      w_state_q <= WIdle;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      wr_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (s_axi_ctrl_awvalid) begin
            wr_idx_q  <= s_axi_ctrl_awaddr[ADDR_W-1:2];
            awready_q <= 1'b0;
          end
          if (s_axi_ctrl_wvalid) begin
            wdata_q  <= s_axi_ctrl_wdata;
            wstrb_q  <= s_axi_ctrl_wstrb;
            wready_q <= 1'b0;
          end
          if (s_axi_ctrl_awvalid && s_axi_ctrl_wvalid) w_state_q <= WCommit;
          else if (s_axi_ctrl_awvalid)                 w_state_q <= WHaveAw;
          else if (s_axi_ctrl_wvalid)                  w_state_q <= WHaveW;
        end
        WHaveAw: begin
          if (s_axi_ctrl_wvalid) begin
            wdata_q   <= s_axi_ctrl_wdata;
            wstrb_q   <= s_axi_ctrl_wstrb;
            wready_q  <= 1'b0;
            w_state_q <= WCommit;
          end
        end
        WHaveW: begin
          if (s_axi_ctrl_awvalid) begin
            wr_idx_q  <= s_axi_ctrl_awaddr[ADDR_W-1:2];
            awready_q <= 1'b0;
            w_state_q <= WCommit;
          end
        end
        WCommit: begin
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_oor ? 2'b10 : 2'b00;
          w_state_q <= WResp;
        end
        WResp: begin
          if (s_axi_ctrl_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Register file; the commit cycle of the write FSM is the only write port.
  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_arst) begin
    if (s_axi_ctrl_arst) begin
      ctrl_q       <= '0;
      int_en_q     <= '0;
      int_status_q <= '0;
      cfg_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_commit && wr_idx32 == 32'd1) begin
        ctrl_q <= merge(ctrl_q, wdata_q, wmask);
      end
      if (wr_commit && wr_idx32 == 32'd2) begin
        int_en_q <= (int_en_q & ~wmask[INT_W-1:0]) | (wdata_q[INT_W-1:0] & wmask[INT_W-1:0]);
      end
      for (int i = 0; i < int'(NumCfg); i++) begin
        if (wr_commit && wr_idx32 == 32'(i + 4)) begin
          cfg_q[i] <= merge(cfg_q[i], wdata_q, wmask);
        end
      end
      // Set wins over a simultaneous W1C of the same bit.
      int_status_q <= (int_status_q & ~status_clr) | int_src;
      irq_q        <= |(int_status_q & int_en_q);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = 2'b00;
    if (rd_idx32 >= NUM_REGS) begin
      rd_resp = 2'b10;
    end else if (rd_idx32 == 32'd0) begin
      rd_data = VERSION;
    end else if (rd_idx32 == 32'd1) begin
      rd_data = ctrl_q;
    end else if (rd_idx32 == 32'd2) begin
      rd_data[INT_W-1:0] = int_en_q;
    end else if (rd_idx32 == 32'd3) begin
      rd_data[INT_W-1:0] = int_status_q;
    end else begin
      for (int i = 0; i < int'(NumCfg); i++) begin
        if (rd_idx32 == 32'(i + 4)) rd_data = cfg_q[i];
      end
    end
  end

  // Read FSM: data is sampled at the AR handshake and held until accepted.
  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_arst) begin
    if (s_axi_ctrl_arst) begin
      r_state_q <= RIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (s_axi_ctrl_arvalid) begin
            rdata_q   <= rd_data;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= RResp;
          end
        end
        RResp: begin
          if (s_axi_ctrl_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign s_axi_ctrl_awready = awready_q;
  assign s_axi_ctrl_wready  = wready_q;
  assign s_axi_ctrl_bvalid  = bvalid_q;
  assign s_axi_ctrl_bresp   = bresp_q;
  assign s_axi_ctrl_arready = arready_q;
  assign s_axi_ctrl_rvalid  = rvalid_q;
  assign s_axi_ctrl_rdata   = rdata_q;
  assign s_axi_ctrl_rresp   = rresp_q;
  assign ctrl_out           = ctrl_q;
  assign cfg_out            = cfg_q;
  assign irq                = irq_q;

endmodule

// File: tb/tb_axil_i2s_ctrl_regs.sv
module tb_axil_i2s_ctrl_regs;

  localparam int NR = 8;
  localparam int AW = 8;
  localparam int IW = 8;
  localparam logic [31:0] VER   = 32'h0002_0000;
  localparam logic [31:0] IMASK = 32'((64'd1 << IW) - 64'd1);
  localparam int CW = (NR - 4) * 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic          wvalid = 1'b0, wready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic          rvalid, rready = 1'b0;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic [IW-1:0] int_src = '0;
  logic [31:0]   ctrl_out;
  logic [CW-1:0] cfg_out;
  logic          irq;

  always #5 clk = ~clk;

  axil_i2s_ctrl_regs #(
    .NUM_REGS(NR), .ADDR_W(AW), .INT_W(IW), .VERSION(VER)
  ) dut (
    .s_axi_ctrl_aclk(clk), .s_axi_ctrl_arst(rst),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
    .s_axi_ctrl_wstrb(wstrb),
    .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready), .s_axi_ctrl_bresp(bresp),
    .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready), .s_axi_ctrl_araddr(araddr),
    .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready), .s_axi_ctrl_rdata(rdata),
    .s_axi_ctrl_rresp(rresp),
    .int_src(int_src), .ctrl_out(ctrl_out), .cfg_out(cfg_out), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- Behavioural model ----------------
  // Register contents as seen after the most recent clock edge.
  logic [31:0]   m_reg [NR];
  logic          m_irq;
  logic [IW-1:0] src_last;
  logic          bv_prev, rv_prev;
  int            pend_idx, rd_pend;
  logic [31:0]   pend_data;
  logic [3:0]    pend_strb;
  logic [31:0]   e_rd, m_clr, m_mk;
  logic [1:0]    e_rr;
  logic          irq_new;
  logic [CW-1:0] e_cfg;

  // Runs between edges: advances the model by the edge just passed, then compares.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_irq = 1'b0; src_last = '0; bv_prev = 1'b0; rv_prev = 1'b0;
    end else begin
      if (rvalid && !rv_prev) begin
        if (rd_pend >= NR) begin e_rd = '0; e_rr = 2'b10; end
        else begin e_rd = (rd_pend == 0) ? VER : m_reg[rd_pend]; e_rr = 2'b00; end
        chk("model_rdata", rdata, e_rd);
        chk("model_rresp", rresp, e_rr);
      end
      irq_new = |(m_reg[3] & m_reg[2]);
      m_clr = '0;
      if (bvalid && !bv_prev) begin
        chk("model_bresp", bresp, (pend_idx >= NR) ? 2'b10 : 2'b00);
        if (pend_idx < NR && pend_idx != 0) begin
          m_mk = bmask(pend_strb);
          if (pend_idx == 3) m_clr = pend_data & m_mk & IMASK;
          else begin
            m_reg[pend_idx] = (m_reg[pend_idx] & ~m_mk) | (pend_data & m_mk);
            if (pend_idx == 2) m_reg[2] = m_reg[2] & IMASK;
          end
        end
      end
      m_reg[3] = (m_reg[3] & ~m_clr) | 32'(src_last);
      m_irq    = irq_new;
      src_last = int_src;
      bv_prev  = bvalid;
      rv_prev  = rvalid;
      for (int i = 0; i < NR - 4; i++) e_cfg[i*32 +: 32] = m_reg[i+4];
      chk("model_ctrl_out", ctrl_out, m_reg[1]);
      chk("model_cfg_out", cfg_out, e_cfg);
      chk("model_irq", irq, m_irq);
    end
  end

  // ---------------- Drivers ----------------
  task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] strb,
                    input int awd, input int wd, input int bhold, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    pend_idx = idx; pend_data = data; pend_strb = strb;
    fork
      begin
        for (int i = 0; i < awd; i++) begin @(posedge clk); #1; end
        awaddr = AW'(idx * 4); awvalid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 50 && !awready; k++) @(negedge clk);
        if (!awready) timeout("aw_handshake");
        @(posedge clk); #1 awvalid = 1'b0;
      end
      begin
        for (int i = 0; i < wd; i++) begin @(posedge clk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 50 && !wready; k++) @(negedge clk);
        if (!wready) timeout("w_handshake");
        @(posedge clk); #1 wvalid = 1'b0;
      end
    join
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin timeout("bvalid"); return; end
    resp = bresp;
    for (int i = 0; i < bhold; i++) begin
      chk("bvalid_held", bvalid, 1'b1);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    chk("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic rd(input int idx, input int rdly, output logic [31:0] data,
                    output logic [1:0] resp);
    data = 'x; resp = 2'bxx;
    rd_pend = idx;
    araddr = AW'(idx * 4); arvalid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 50 && !arready; k++) @(negedge clk);
    if (!arready) begin timeout("ar_handshake"); arvalid = 1'b0; return; end
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    if (!rvalid) begin timeout("rvalid"); return; end
    data = rdata; resp = rresp;
    for (int i = 0; i < rdly; i++) @(negedge clk);
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    chk("rvalid_drop", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
  endtask

  logic rand_src_en = 1'b0;
  always @(posedge clk) begin
    if (rand_src_en) begin
      #1 int_src = ($urandom_range(0, 3) == 0) ? IW'($urandom) : '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] d;
  logic [1:0]  r, r2;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cfg", cfg_out, '0);
    @(posedge clk); #1;
    rd(0, 0, d, r);
    chk("ver_rdata", d, 32'h0002_0000);
    chk("ver_rresp", r, 2'b00);
    rd(1, 1, d, r);
    chk("ctrl_rst_rdata", d, 32'h0);

    // Byte-lane write with W two cycles ahead of AW, bready held low 3 cycles
    wr(1, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    wr(1, 32'hA5A5_5A5A, 4'b0101, 2, 0, 3, r);
    chk("strb_ctrl_out", ctrl_out, 32'hFFA5_FF5A);
    chk("strb_bresp", r, 2'b00);

    // Out-of-range access
    wr(NR, 32'h1111_2222, 4'hF, 0, 1, 0, r);
    chk("oor_bresp", r, 2'b10);
    rd(NR, 0, d, r);
    chk("oor_rresp", r, 2'b10);
    chk("oor_rdata", d, 32'h0);
    chk("oor_ctrl_kept", ctrl_out, 32'hFFA5_FF5A);

    // Interrupts
    wr(2, 32'h0000_0003, 4'hF, 0, 0, 0, r);
    int_src = 8'h05;
    @(posedge clk); #1 int_src = '0;
    chk("irq_lag", irq, 1'b0);
    @(posedge clk); #1;
    chk("irq_rise", irq, 1'b1);
    rd(3, 0, d, r);
    chk("status_set", d, 32'h5);
    wr(3, 32'h1, 4'hF, 0, 0, 0, r);
    rd(3, 0, d, r);
    chk("status_w1c", d, 32'h4);
    chk("irq_after_w1c", irq, 1'b0);
    fork
      wr(3, 32'h4, 4'h1, 0, 0, 0, r);
      begin
        @(posedge clk); #1 int_src = 8'h04;
        @(posedge clk); #1 int_src = '0;
      end
    join
    rd(3, 0, d, r);
    chk("status_set_wins", d, 32'h4);

    // Top cfg register and VER write
    wr(NR - 1, 32'h1234_5678, 4'hF, 1, 0, 0, r);
    chk("cfg_top", cfg_out[CW-1 -: 32], 32'h1234_5678);
    wr(0, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, r);
    chk("ver_wr_bresp", r, 2'b00);
    rd(0, 0, d, r);
    chk("ver_unchanged", d, 32'h0002_0000);

    // Reset while holding only AW
    wr(5, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r);
    int_src = 8'h01;
    @(posedge clk); #1 int_src = '0;
    @(posedge clk); #1;
    chk("irq_pre_reset", irq, 1'b1);
    awaddr = AW'(4); awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_awready", awready, 1'b1);
    chk("arst_wready", wready, 1'b1);
    chk("arst_bvalid", bvalid, 1'b0);
    chk("arst_ctrl", ctrl_out, 32'h0);
    chk("arst_cfg", cfg_out, '0);
    chk("arst_irq", irq, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    rd(1, 0, d, r);  chk("arst_rd1", d, 32'h0);
    rd(2, 0, d, r);  chk("arst_rd2", d, 32'h0);
    rd(3, 0, d, r);  chk("arst_rd3", d, 32'h0);
    rd(5, 0, d, r);  chk("arst_rd5", d, 32'h0);

    // Reset while rvalid is held
    wr(4, 32'h0BAD_CAFE, 4'hF, 0, 0, 0, r);
    rd_pend = 4;
    araddr = AW'(16); arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_held", rvalid, 1'b1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_rvalid", rvalid, 1'b0);
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_rresp", rresp, 2'b00);
    chk("arst_arready", arready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    rd(4, 0, d, r);  chk("arst_rd4", d, 32'h0);

    // Randomized concurrent traffic against the model
    rand_src_en = 1'b1;
    for (int it = 0; it < 150; it++) begin
      int wi, ri;
      logic [31:0] wdv, rdv;
      wi = $urandom_range(0, NR + 1);
      ri = $urandom_range(0, NR + 1);
      wdv = $urandom;
      fork
        wr(wi, wdv, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 2), r2);
        rd(ri, $urandom_range(0, 2), rdv, r);
      join
    end
    rand_src_en = 1'b0;
    @(posedge clk); #2 int_src = '0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
